// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the multiply/divide unit.
package mips_pkg;
    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } md_op_t;
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } md_state_t;
    localparam int MD_ITERS = 32;
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add multiply or restoring-divide iteration on unsigned magnitudes.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   operand_i,
    input  logic               div_i,
    output logic [2*WIDTH-1:0] acc_o
);
    logic [WIDTH:0]   sum, shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;
    always_comb begin
        sum     = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, operand_i} : '0);
        shifted = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
        ge      = shifted >= {1'b0, operand_i};
        diff    = shifted[WIDTH-1:0] - operand_i;
        // multiply: upper half accumulates, multiplier shifts out of the lower half
        // divide: upper half is the remainder, quotient bits shift into the lower half
        acc_o   = !div_i ? {sum, acc_i[WIDTH-1:1]}
                : ge     ? {diff, acc_i[WIDTH-2:0], 1'b1}
                         : {shifted[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(MD_ITERS);
    md_state_t          state_q, state_d;
    md_op_t             op_q, op_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, acc_step, prod;
    logic [WIDTH-1:0]   opnd_q, opnd_d, hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0]   mag_a, mag_b, quo, rem;
    logic               sign_a_q, sign_a_d, sign_b_q, sign_b_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic               is_signed, go;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc_i     (acc_q),
        .operand_i (opnd_q),
        .div_i     (op_q[1]),
        .acc_o     (acc_step)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MULT;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush)
            state_d = ST_IDLE;
        else
            case (state_q)
                ST_IDLE: state_d = start ? ST_CALC : ST_IDLE;
                ST_CALC: state_d = cnt_q == CW'(MD_ITERS - 1) ? ST_FIX : ST_CALC;
                default: state_d = ST_IDLE;
            endcase
    end

    always_comb begin
        go        = state_q == ST_IDLE && start && !flush;
        is_signed = !op[0];
        mag_a     = (is_signed && src_a[WIDTH-1]) ? -src_a : src_a;
        mag_b     = (is_signed && src_b[WIDTH-1]) ? -src_b : src_b;
        prod      = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
        quo       = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem       = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        op_d      = op_q;
        sign_a_d  = sign_a_q;
        sign_b_d  = sign_b_q;
        acc_d     = state_q == ST_CALC ? acc_step : acc_q;
        opnd_d    = opnd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        cnt_d     = (state_q == ST_CALC && !flush) ? cnt_q + 1'b1 : '0;
        busy_d    = state_d != ST_IDLE;
        if (go) begin
            op_d     = md_op_t'(op);
            sign_a_d = is_signed && src_a[WIDTH-1];
            sign_b_d = is_signed && src_b[WIDTH-1];
            acc_d    = {{WIDTH{1'b0}}, op[1] ? mag_a : mag_b};
            opnd_d   = op[1] ? mag_b : mag_a;
        end
        // a zero divisor leaves the dividend in the remainder, so only LO needs forcing
        if (state_q == ST_FIX && !flush) begin
            hi_d   = op_q[1] ? rem : prod[2*WIDTH-1:WIDTH];
            lo_d   = op_q[1] ? (opnd_q == '0 ? '1 : quo) : prod[WIDTH-1:0];
            done_d = 1'b1;
        end
        if (state_q == ST_IDLE && !start) begin
            hi_d = mthi ? wdata : hi_d;
            lo_d = mtlo ? wdata : lo_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 32-bit multiply/divide unit beside the EX-stage ALU. It executes MULT/MULTU/DIV/DIVU over 33 cycles and owns the HI/LO architectural registers. It also services MTHI/MTLO writes and exports a registered `busy` that the hazard unit uses to stall the pipeline. Operands come from the EX forwarding muxes, after forwarding.

## Interface
Parameters:
- `WIDTH`, 32: operand width; only 32 is supported.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: launch a multiply/divide; sampled only in IDLE.
- `op` in 2: operation select, valid with `start`.
- `src_a` in 32: rs operand (dividend / multiplicand), post-forwarding.
- `src_b` in 32: rt operand (divisor / multiplier), post-forwarding.
- `flush` in 1: squash any in-flight operation.
- `mthi` in 1: write `wdata` to HI.
- `mtlo` in 1: write `wdata` to LO.
- `wdata` in 32: MTHI/MTLO data.
- `busy` out 1: registered; high while state ≠ IDLE.
- `done` out 1: one-cycle registered pulse when HI/LO take a result.
- `hi` out 32: HI register.
- `lo` out 32: LO register.

## Operation
- `op` encoding: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- States:
  - IDLE → CALC on `start && !flush`.
  - CALC → FIX when the iteration counter reaches 31.
  - FIX → IDLE always.
  - Any state → IDLE on `flush`.
- On start, the block latches `op`.
  - Signed ops: latch |src_a| and |src_b| and record the sign bits.
  - Unsigned ops: latch the raw operands.
- Signed-ness is resolved only at entry (operand magnitudes) and in FIX (result sign correction). CALC works on unsigned magnitudes only.
- Multiply in CALC: shift-add, one multiplier bit per cycle, into a 64-bit accumulator.
- Divide in CALC: restoring division, one quotient bit per cycle, with a 33-bit partial remainder.
- FIX computes the final result and writes HI/LO:
  - Multiply: the product is negated when the operand signs differ. HI = product[63:32], LO = product[31:0].
  - Divide: quotient sign = sign_a XOR sign_b; remainder sign = sign_a. LO = quotient, HI = remainder.
- Divide by zero, signed or unsigned: LO = 32'hFFFF_FFFF, HI = src_a as latched at start (original signed value for DIV).
- DIV 0x8000_0000 / 0xFFFF_FFFF: LO = 0x8000_0000, HI = 0. This falls out of the magnitude algorithm and needs no special case.
- MTHI/MTLO:
  - Honoured only in IDLE with `start` low. Both may assert in the same cycle.
  - Ignored while `busy`.
  - If `start` is high in the same cycle, `start` wins and the writes are dropped.
- `start` while busy is ignored. The hazard unit guarantees this does not occur.
- `flush`:
  - In CALC or FIX: next state is IDLE, HI/LO unchanged, no `done`.
  - In IDLE: any `start` in the same cycle is ignored.
  - It does not block MTHI/MTLO in IDLE.
- Reset: state IDLE, counter 0; `busy`, `done`, `hi`, `lo` and all internal operand/accumulator registers are 0. Reset mid-operation abandons the operation.

## Timing
- Edge E0: `start` sampled in IDLE. `busy` = 1 after E0.
- Edges E1..E32: 32 iterations, counter 0..31. At E32 the state moves to FIX.
- Edge E33: HI/LO written, state → IDLE. `done` = 1 and `busy` = 0 in the cycle after E33.
- `busy` is high for exactly 33 cycles; the result is visible in `hi`/`lo` the cycle after E33.
- A new `start` may be sampled at E34, i.e. the cycle in which `done` is high.
- MTHI/MTLO have 1-cycle write latency: the value is visible after the sampling edge.
- `hi`/`lo` are plain register outputs with no read bypass. The hazard unit must stall MFHI/MFLO while `busy`.
- `done` never asserts except after FIX.

## Structure
- Shared package `mips_pkg`:
  - `md_op_t` (the 4 op codes).
  - `md_state_t` (IDLE, CALC, FIX).
  - `MD_ITERS = 32`.
- One sub-module: `muldiv_step`. It is combinational: one shift-add or restoring-subtract iteration.
  - Inputs: accumulator/remainder, operand, mode.
  - Outputs: next accumulator/remainder.
- FSM, counter, sign fix-up and HI/LO registers live in `muldiv_unit`.

## Test plan
- MULTU 0xFFFF_FFFF × 0xFFFF_FFFF → `busy` high 33 cycles, then HI = 0xFFFF_FFFE, LO = 0x0000_0001, `done` pulses once.
- MULT −3 × 5 → HI = 0xFFFF_FFFF, LO = 0xFFFF_FFF1.
- DIV −7 / 2 → LO = 0xFFFF_FFFD, HI = 0xFFFF_FFFF.
- DIVU 7 / 3 → LO = 2, HI = 1.
- Divide edge cases:
  - DIVU 7 / 0 → HI = 7, LO = 0xFFFF_FFFF.
  - DIV 0x8000_0000 / −1 → LO = 0x8000_0000, HI = 0.
- Flush and start handling:
  - MTHI 0x1234, MTLO 0x5678 in IDLE → visible next cycle.
  - Start DIVU, `flush` at CALC cycle 10 → `busy` low next cycle, HI/LO still 0x1234/0x5678, no `done`.
  - `start` + `mthi` in the same cycle → operation runs, HI not written from `wdata`.
- Reset and busy-blocked writes:
  - `rst` asserted mid-CALC → next cycle `busy` = 0, HI = LO = 0, `done` = 0.
  - Start during `busy` and MTLO during `busy` → both ignored, and the in-flight result is unaffected.
